// File: rtl/path_reconstruct_if.sv
// Route reconstruction bus: predecessor/distance table read port plus the
// forward-order route stream. master = reconstruction engine, slave = the
// table owner / route consumer side.
interface path_reconstruct_if #(
  parameter int ID_WIDTH   = 9,
  parameter int DIST_WIDTH = 14
) ();
  logic [ID_WIDTH-1:0]   tbl_addr;
  logic [ID_WIDTH-1:0]   tbl_pred;
  logic [DIST_WIDTH-1:0] tbl_dist;
  logic [ID_WIDTH-1:0]   path_id;
  logic                  path_valid;
  logic                  path_ready;
  logic                  path_last;

  modport master (
    output tbl_addr,
    input  tbl_pred, tbl_dist,
    output path_id, path_valid, path_last,
    input  path_ready
  );

  modport slave (
    input  tbl_addr,
    output tbl_pred, tbl_dist,
    input  path_id, path_valid, path_last,
    output path_ready
  );
endinterface

// File: rtl/path_reconstruct.sv
// Walks the Dijkstra predecessor table from dest back to start, buffers the
// node IDs in a LIFO and streams them out start-first over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// CHECK | range-check latched start/dest IDs
// ISSUE | table address presented for cur
// WAIT  | table data valid; push cur, decide next hop
// EMIT  | stream LIFO top until empty
// DONE  | one-cycle completion pulse
module path_reconstruct #(
  parameter int                    MAX_NODES  = 10,
  parameter int                    ID_WIDTH   = 9,
  parameter int                    DIST_WIDTH = 14,
  parameter logic [DIST_WIDTH-1:0] INF_DIST   = 14'h3FFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ID_WIDTH-1:0] start_id,
  input  logic [ID_WIDTH-1:0] dest_id,
  path_reconstruct_if.master  bus,
  output logic [ID_WIDTH:0]   path_length,
  output logic                busy,
  output logic                done,
  output logic [1:0]          error
);

  localparam int CNT_W = $clog2(MAX_NODES + 1);
  localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int PL_W  = ID_WIDTH + 1;

  localparam logic [ID_WIDTH-1:0] MAX_ID  = ID_WIDTH'(MAX_NODES);
  localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_NODES);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [PL_W-1:0]     PL_ONE  = PL_W'(1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]          state;
  logic [ID_WIDTH-1:0] s_id;
  logic [ID_WIDTH-1:0] d_id;
  logic [ID_WIDTH-1:0] cur;
  logic [ID_WIDTH-1:0] tbl_addr;
  logic [CNT_W-1:0]    count;
  logic                first_hop;
  logic [ID_WIDTH-1:0] lifo [MAX_NODES];

  logic                unreachable;
  logic                push;
  logic [CNT_W-1:0]    top;

  // The distance word only matters for the destination itself: later hops
  // are on a path Dijkstra already resolved.
  assign unreachable = first_hop && (bus.tbl_dist == INF_DIST);
  assign push        = (state == WAIT) && !unreachable;
  assign top         = count - CNT_ONE;

  // Main sequencer: walk, loop/range/unreachable detection, stream pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s_id        <= '0;
      d_id        <= '0;
      cur         <= '0;
      tbl_addr    <= '0;
      count       <= '0;
      first_hop   <= 1'b0;
      path_length <= '0;
      error       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_id        <= start_id;
            d_id        <= dest_id;
            cur         <= dest_id;
            count       <= '0;
            first_hop   <= 1'b1;
            path_length <= '0;
            error       <= 2'd0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if ((s_id >= MAX_ID) || (d_id >= MAX_ID)) begin
            error <= 2'd1;
            state <= DONE;
          end else begin
            // Address goes out on entry to ISSUE so data lands in WAIT.
            tbl_addr <= cur;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          first_hop <= 1'b0;
          if (unreachable) begin
            error <= 2'd2;
            state <= DONE;
          end else begin
            count <= count + CNT_ONE;
            if (cur == s_id) begin
              path_length <= PL_W'(count) + PL_ONE;
              state       <= EMIT;
            end else if ((count + CNT_ONE) == MAX_CNT) begin
              // A full LIFO without reaching start can only be a cycle.
              error <= 2'd3;
              state <= DONE;
            end else begin
              cur      <= bus.tbl_pred;
              tbl_addr <= bus.tbl_pred;
              state    <= ISSUE;
            end
          end
        end
        EMIT: begin
          if (bus.path_ready) begin
            count <= count - CNT_ONE;
            if (count == CNT_ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // LIFO storage; contents are meaningless outside count, so no reset.
  always_ff @(posedge clk) begin
    if (push) lifo[count[IDX_W-1:0]] <= cur;
  end

  assign bus.tbl_addr   = tbl_addr;
  assign bus.path_valid = (state == EMIT);
  assign bus.path_id    = (state == EMIT) ? lifo[top[IDX_W-1:0]] : '0;
  assign bus.path_last  = (state == EMIT) && (count == CNT_ONE);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: doc/path_reconstruct.md
Name: path_reconstruct

Overview:
- Downstream consumer of the Dijkstra pathfinding engine.
- After Dijkstra reports finished, this block walks the predecessor (neighbour) table from a destination node back to the start node. It buffers the visited IDs in an internal LIFO.
- It then streams the route in forward order (start to destination) over a valid/ready interface to the route-output logic.
- It reports the path length and an error code for unreachable, invalid or looping routes.

Parameters:
- MAX_NODES, 10, number of graph nodes; also the LIFO depth and the hop limit.
- ID_WIDTH, 9, node ID width.
- DIST_WIDTH, 14, distance word width.
- INF_DIST, 14'h3FFF, distance value meaning unreachable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin reconstruction; sampled only in IDLE.
- start_id  in  ID_WIDTH  source node used by Dijkstra.
- dest_id  in  ID_WIDTH  destination node.
- tbl_addr  out  ID_WIDTH  read address into Dijkstra neighbour/distance arrays.
- tbl_pred  in  ID_WIDTH  neighbour[tbl_addr]; valid 1 cycle after address.
- tbl_dist  in  DIST_WIDTH  distance[tbl_addr]; valid 1 cycle after address.
- path_id  out  ID_WIDTH  streamed route node.
- path_valid  out  1  path_id valid.
- path_ready  in  1  consumer accepts path_id.
- path_last  out  1  marks the final node (dest_id).
- path_length  out  ID_WIDTH+1  node count of the route (start and dest inclusive); held until the next start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion, success or error.
- error  out  2  0 none, 1 bad ID, 2 unreachable, 3 loop; held until the next start.

Behaviour:
- Reset: state IDLE; all outputs 0 (tbl_addr=0, path_length=0, error=0); LIFO count=0. Reset applies mid-operation and discards all buffered data.
- States: IDLE, CHECK, ISSUE, WAIT, EMIT, DONE.
- IDLE:
  - On start: latch start_id/dest_id; clear error, path_length and LIFO; cur<=dest_id; go to CHECK.
  - start is ignored while busy.
- CHECK (1 cycle):
  - If start_id>=MAX_NODES or dest_id>=MAX_NODES: error<=1, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: tbl_addr=cur (registered output, stable through WAIT); go to WAIT.
- WAIT: tbl_pred/tbl_dist are valid here.
  - First hop only: if tbl_dist==INF_DIST, error<=2, go to DONE, nothing pushed.
  - Otherwise push cur onto the LIFO.
  - If cur==start_id: path_length<=count+1; go to EMIT.
  - Else if count+1==MAX_NODES: error<=3, go to DONE.
  - Else cur<=tbl_pred; go to ISSUE.
- Walk cost: 2 cycles per hop. dest==start yields a one-node path; its tbl_pred is not used.
- EMIT:
  - path_valid=1 and path_id=LIFO top.
  - path_last=1 when count==1.
  - On path_valid&&path_ready: pop.
  - path_id/path_valid/path_last stay stable while path_ready is low.
  - After the last handshake go to DONE.
  - One node per cycle under continuous ready.
- DONE: done=1 for exactly 1 cycle; path_valid=0; return to IDLE.
- On the error path, no path_valid is ever asserted.
- LIFO: MAX_NODES entries, register array. Push and pop are never simultaneous. Push only occurs when count<MAX_NODES, guaranteed by the loop check.
- Widths: comparisons are unsigned. The count register is wide enough to hold MAX_NODES.

Test Plan:
- Chain (MAX_NODES=10): pred[3]=1, pred[1]=0, dist[3]=7, start_id=0, dest_id=3, ready held high.
  - Required: path_id 0,1,3 on consecutive cycles; path_last on 3; path_length=3; error=0; done 1 cycle after the last beat.
- dest_id=start_id=5, dist[5]=0.
  - Required: single beat path_id=5 with path_last=1; path_length=1.
- dist[7]=14'h3FFF, dest_id=7.
  - Required: no path_valid; error=2; done pulse; tbl_addr read exactly once (7).
- Loop: pred[4]=5, pred[5]=4, start 0, dest 4.
  - Required: error=3 after 10 pushes; done pulse; no path_valid.
- Backpressure on the chain case: ready pattern 0,0,1,0,1,1.
  - Required: path_id holds 0 for 3 cycles, then 1, then 3. No beat lost or duplicated.
  - start pulsed mid-EMIT is ignored.
- dest_id=12: error=1 in 2 cycles, no tbl reads.
- Reset asserted mid-EMIT: next cycle path_valid=0, busy=0, error=0, path_length=0.
